// File: rtl/usb_pkt_fifo.sv
// Store-and-forward packet FIFO: USB bulk OUT byte stream in, AXI-stream out.
// A packet becomes visible downstream only after its tlast byte commits; overflowing packets are dropped.
module usb_pkt_fifo #(
  parameter int WIDTH  = 8,
  parameter int ABITS  = 11,
  parameter int OUTREG = 1
) (
  input  logic             clock,
  input  logic             arst_n,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tkeep,
  output logic [WIDTH-1:0] m_tdata,
  output logic [ABITS:0]   level_o,
  output logic [ABITS:0]   pkts_o,
  output logic             drop_o
);

  localparam int DEPTH = 1 << ABITS;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DROP} state_t;

  state_t         r_state;
  logic [ABITS:0] r_wr_ptr;
  logic [ABITS:0] r_cm_ptr;
  logic [ABITS:0] r_rd_ptr;
  logic [ABITS:0] r_pkts;
  logic           r_ready;
  logic           r_drop;
  logic [WIDTH:0] r_mem [DEPTH];
  logic           r_q_valid;
  logic [WIDTH:0] r_q;

  logic           w_accept;
  logic           w_full;
  logic           w_wr_en;
  logic           w_commit;
  logic           w_sink_ready;
  logic           w_q_adv;
  logic           w_issue;
  logic           w_m_valid;
  logic [WIDTH:0] w_m_word;
  logic [1:0]     w_held;
  logic           w_pop_last;

  assign w_accept = s_tvalid & r_ready;
  assign w_full   = ((r_wr_ptr - r_rd_ptr) == (ABITS+1)'(DEPTH));
  assign w_wr_en  = w_accept & ~w_full & (r_state != ST_DROP);
  assign w_commit = w_wr_en & s_tlast;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_ready  <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_drop  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FILL: begin
          if (w_accept) begin
            if (!w_full) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (s_tlast) begin
                r_cm_ptr <= r_wr_ptr + 1'b1;
                r_state  <= ST_IDLE;
              end else begin
                r_state  <= ST_FILL;
              end
            end else begin
              // Overflow: discard the partial packet and swallow the rest of it.
              r_wr_ptr <= r_cm_ptr;
              if (s_tlast) begin
                r_drop  <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_DROP;
              end
            end
          end
        end
        ST_DROP: begin
          if (w_accept && s_tlast) begin
            r_drop  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the buffer array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr[ABITS-1:0]] <= {s_tlast, s_tdata};
  end

  assign w_q_adv = ~r_q_valid | w_sink_ready;
  assign w_issue = w_q_adv & (r_rd_ptr != r_cm_ptr);

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_ptr  <= '0;
      r_q_valid <= 1'b0;
      r_q       <= '0;
    end else if (w_q_adv) begin
      r_q_valid <= w_issue;
      if (w_issue) begin
        r_q      <= r_mem[r_rd_ptr[ABITS-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic           r_o_valid;
    logic [WIDTH:0] r_o;

    assign w_sink_ready = ~r_o_valid | m_tready;

    always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
        r_o_valid <= 1'b0;
        r_o       <= '0;
      end else if (w_sink_ready) begin
        r_o_valid <= r_q_valid;
        if (r_q_valid) r_o <= r_q;
      end
    end

    assign w_m_valid = r_o_valid;
    assign w_m_word  = r_o;
    assign w_held    = {1'b0, r_q_valid} + {1'b0, r_o_valid};
  end else begin : g_direct
    assign w_sink_ready = m_tready;
    assign w_m_valid    = r_q_valid;
    assign w_m_word     = r_q;
    assign w_held       = {1'b0, r_q_valid};
  end

  assign w_pop_last = w_m_valid & m_tready & w_m_word[WIDTH];

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      r_pkts <= '0;
    end else begin
      case ({w_commit, w_pop_last})
        2'b10:   r_pkts <= r_pkts + 1'b1;
        2'b01:   r_pkts <= r_pkts - 1'b1;
        default: r_pkts <= r_pkts;
      endcase
    end
  end

  // Words already pulled from SRAM into the output stage still count as unread.
  assign level_o  = (r_cm_ptr - r_rd_ptr) + {{(ABITS-1){1'b0}}, w_held};
  assign pkts_o   = r_pkts;
  assign drop_o   = r_drop;
  assign s_tready = r_ready;
  assign m_tvalid = w_m_valid;
  assign m_tkeep  = w_m_valid;
  assign m_tlast  = w_m_word[WIDTH];
  assign m_tdata  = w_m_word[WIDTH-1:0];

endmodule

// File: tb/tb_usb_pkt_fifo.sv
// Self-checking bench for usb_pkt_fifo: three instances (2048/OUTREG=1, 16/OUTREG=1, 64/OUTREG=0)
// checked against a byte-queue model of committed packets.
module tb_usb_pkt_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         sel;
  logic       d_tvalid, d_tlast, d_tready;
  logic [7:0] d_tdata;
  logic       rnd_ready;

  logic a_sv, a_sr, a_mr, a_mv, a_ml, a_mk, a_dr;
  logic [7:0] a_md;
  logic [11:0] a_lv, a_pk;
  logic b_sv, b_sr, b_mr, b_mv, b_ml, b_mk, b_dr;
  logic [7:0] b_md;
  logic [4:0] b_lv, b_pk;
  logic c_sv, c_sr, c_mr, c_mv, c_ml, c_mk, c_dr;
  logic [7:0] c_md;
  logic [6:0] c_lv, c_pk;

  assign a_sv = d_tvalid && (sel == 0);
  assign b_sv = d_tvalid && (sel == 1);
  assign c_sv = d_tvalid && (sel == 2);
  assign a_mr = (sel == 0) ? d_tready : 1'b1;
  assign b_mr = (sel == 1) ? d_tready : 1'b1;
  assign c_mr = (sel == 2) ? d_tready : 1'b1;

  usb_pkt_fifo #(.WIDTH(8), .ABITS(11), .OUTREG(1)) u_big (
    .clock(clk), .arst_n(rst_n),
    .s_tvalid(a_sv), .s_tready(a_sr), .s_tlast(d_tlast), .s_tdata(d_tdata),
    .m_tvalid(a_mv), .m_tready(a_mr), .m_tlast(a_ml), .m_tkeep(a_mk), .m_tdata(a_md),
    .level_o(a_lv), .pkts_o(a_pk), .drop_o(a_dr)
  );

  usb_pkt_fifo #(.WIDTH(8), .ABITS(4), .OUTREG(1)) u_small (
    .clock(clk), .arst_n(rst_n),
    .s_tvalid(b_sv), .s_tready(b_sr), .s_tlast(d_tlast), .s_tdata(d_tdata),
    .m_tvalid(b_mv), .m_tready(b_mr), .m_tlast(b_ml), .m_tkeep(b_mk), .m_tdata(b_md),
    .level_o(b_lv), .pkts_o(b_pk), .drop_o(b_dr)
  );

  usb_pkt_fifo #(.WIDTH(8), .ABITS(6), .OUTREG(0)) u_direct (
    .clock(clk), .arst_n(rst_n),
    .s_tvalid(c_sv), .s_tready(c_sr), .s_tlast(d_tlast), .s_tdata(d_tdata),
    .m_tvalid(c_mv), .m_tready(c_mr), .m_tlast(c_ml), .m_tkeep(c_mk), .m_tdata(c_md),
    .level_o(c_lv), .pkts_o(c_pk), .drop_o(c_dr)
  );

  logic        mon_sr, mon_v, mon_l, mon_k, mon_dr;
  logic [7:0]  mon_d;
  logic [11:0] mon_lv, mon_pk;

  always_comb begin
    mon_sr = a_sr; mon_v = a_mv; mon_l = a_ml; mon_k = a_mk; mon_dr = a_dr;
    mon_d = a_md; mon_lv = a_lv; mon_pk = a_pk;
    if (sel == 1) begin
      mon_sr = b_sr; mon_v = b_mv; mon_l = b_ml; mon_k = b_mk; mon_dr = b_dr;
      mon_d = b_md; mon_lv = 12'(b_lv); mon_pk = 12'(b_pk);
    end else if (sel == 2) begin
      mon_sr = c_sr; mon_v = c_mv; mon_l = c_ml; mon_k = c_mk; mon_dr = c_dr;
      mon_d = c_md; mon_lv = 12'(c_lv); mon_pk = 12'(c_pk);
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vrise = -1;
  int tl_cyc = 0;
  int drop_cnt = 0;
  int n_out = 0;
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [8:0] prev_word  = '0;
  logic [8:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output checker, sampled on the falling edge while inputs are stable.
  task automatic monitor();
    logic [8:0] w;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      return;
    end
    check("tkeep", mon_k, mon_v);
    if (prev_stall) begin
      check("hold_valid", mon_v, 1);
      check("hold_word", {mon_l, mon_d}, prev_word);
    end
    if (mon_v && !prev_valid && vrise < 0) vrise = cyc;
    if (mon_dr) drop_cnt++;
    if (mon_v && d_tready) begin
      if (exp_q.size() == 0) begin
        check("queue_underrun", exp_q.size(), 1);
      end else begin
        w = exp_q.pop_front();
        check("beat", {mon_l, mon_d}, w);
        n_out++;
      end
    end
    prev_stall = mon_v && !d_tready;
    prev_word  = {mon_l, mon_d};
    prev_valid = mon_v;
  endtask

  // NOTE: bench inputs change with blocking assignments 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rnd_ready) d_tready = ($urandom_range(1, 0) == 1);
  endtask

  task automatic apply_reset(input int s);
    rst_n = 1'b0;
    d_tvalid = 1'b0; d_tlast = 1'b0; d_tdata = '0; d_tready = 1'b1; rnd_ready = 1'b0;
    sel = s;
    exp_q.delete();
    repeat (2) tick();
    check("rst_tvalid", mon_v, 0);
    check("rst_tdata", mon_d, 0);
    check("rst_tlast", mon_l, 0);
    check("rst_level", mon_lv, 0);
    check("rst_pkts", mon_pk, 0);
    check("rst_drop", mon_dr, 0);
    check("rst_tready", mon_sr, 0);
    rst_n = 1'b1;
    tick();
    check("tready_after_rst", mon_sr, 1);
  endtask

  task automatic send_pkt(input int len, input int base, input bit rnd, input bit push, input bit gaps);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(7, 0) == 0) begin
        d_tvalid = 1'b0;
        tick();
      end
      w[7:0] = rnd ? 8'($urandom) : 8'(base + i);
      w[8]   = (i == len - 1);
      d_tvalid = 1'b1; d_tdata = w[7:0]; d_tlast = w[8];
      if (push) exp_q.push_back(w);
      tick();
    end
    tl_cyc = cyc;
    d_tvalid = 1'b0; d_tlast = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic wait_space(input int len, input int depth);
    int n = 0;
    while (exp_q.size() + len > depth && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("space_timeout", exp_q.size() + len, depth);
  endtask

  typedef struct {
    int sel;
    int len;
    int base;
    int lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0, o0, sent, depth;
    vecs[0] = '{sel: 0, len: 8, base: 'h01, lat: 3};
    vecs[1] = '{sel: 0, len: 1, base: 'h55, lat: 3};
    vecs[2] = '{sel: 1, len: 7, base: 'h10, lat: 3};
    vecs[3] = '{sel: 2, len: 1, base: 'hA0, lat: 2};
    vecs[4] = '{sel: 2, len: 6, base: 'h30, lat: 2};

    // Single packets: latency from tlast beat, counters, and byte order.
    for (int v = 0; v < 5; v++) begin
      apply_reset(vecs[v].sel);
      check("pkts_idle", mon_pk, 0);
      vrise = -1;
      o0 = n_out;
      send_pkt(vecs[v].len, vecs[v].base, 1'b0, 1'b1, 1'b0);
      check("pkts_committed", mon_pk, 1);
      check("level_committed", mon_lv, vecs[v].len);
      drain(200);
      check("latency", vrise - tl_cyc, vecs[v].lat);
      check("pkts_drained", mon_pk, 0);
      check("level_drained", mon_lv, 0);
      check("beats_out", n_out - o0, vecs[v].len);
    end

    // 512-byte and 1-byte packets held back, then released.
    apply_reset(0);
    d_tready = 1'b0;
    send_pkt(512, 0, 1'b1, 1'b1, 1'b0);
    send_pkt(1, 0, 1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    check("level_513", mon_lv, 513);
    check("pkts_2", mon_pk, 2);
    o0 = n_out;
    d_tready = 1'b1;
    drain(2000);
    check("beats_513", n_out - o0, 513);
    check("pkts_after_513", mon_pk, 0);

    // 16-word buffer: second 10-byte packet overflows and is dropped.
    apply_reset(1);
    d_tready = 1'b0;
    d0 = drop_cnt;
    send_pkt(10, 'h20, 1'b0, 1'b1, 1'b0);
    send_pkt(10, 'h40, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("drop_once", drop_cnt - d0, 1);
    check("level_after_drop", mon_lv, 10);
    check("pkts_after_drop", mon_pk, 1);
    send_pkt(3, 'h60, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check("level_after_refill", mon_lv, 13);
    check("pkts_after_refill", mon_pk, 2);
    o0 = n_out;
    d_tready = 1'b1;
    drain(200);
    check("beats_after_drop", n_out - o0, 13);
    check("drop_total", drop_cnt - d0, 1);

    // Wrap-around in the 16-word buffer with random back-pressure.
    apply_reset(1);
    rnd_ready = 1'b1;
    d0 = drop_cnt;
    o0 = n_out;
    for (int p = 0; p < 5; p++) begin
      wait_space(7, 16);
      send_pkt(7, 0, 1'b1, 1'b1, 1'b0);
    end
    drain(2000);
    check("wrap_drops", drop_cnt - d0, 0);
    check("wrap_beats", n_out - o0, 35);

    // Random packets, 50% back-pressure, registered and direct output stages.
    for (int s = 0; s < 3; s += 2) begin
      apply_reset(s);
      rnd_ready = 1'b1;
      depth = (s == 0) ? 2048 : 64;
      d0 = drop_cnt;
      o0 = n_out;
      sent = 0;
      for (int p = 0; p < 500; p++) begin
        int len;
        len = $urandom_range(64, 1);
        wait_space(len, depth);
        send_pkt(len, 0, 1'b1, 1'b1, 1'b1);
        sent += len;
      end
      drain(20000);
      check("rand_drops", drop_cnt - d0, 0);
      check("rand_beats", n_out - o0, sent);
      check("rand_pkts", mon_pk, 0);
    end

    // Reset mid-packet while a committed packet is being read out.
    apply_reset(0);
    d_tready = 1'b0;
    send_pkt(20, 'h80, 1'b0, 1'b1, 1'b0);
    d_tready = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      d_tvalid = 1'b1; d_tdata = 8'(i + 1); d_tlast = 1'b0;
      tick();
    end
    d_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", mon_v, 0);
    check("midrst_level", mon_lv, 0);
    check("midrst_pkts", mon_pk, 0);
    check("midrst_tready", mon_sr, 0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("midrst_tready_back", mon_sr, 1);
    o0 = n_out;
    send_pkt(2, 'hC0, 1'b0, 1'b1, 1'b0);
    drain(200);
    check("post_rst_beats", n_out - o0, 2);
    check("post_rst_pkts", mon_pk, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
